// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with one-shot or periodic reload.
// Counts down once per clock to zero, pulses tc on the 1->0 step, then stops or reloads.
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             tc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] counter_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;

    // Command priority is load > stop > start; tc defaults low so it is a single-cycle pulse.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        reload_next  = reload_reg;
        tc_next      = 1'b0;
        if (load) begin
            counter_next = load_val;
            reload_next  = load_val;
            state_next   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && (counter != ZERO)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = HOLD;
                    end else if (counter > ONE) begin
                        counter_next = counter - ONE;
                    end else if (counter == ONE) begin
                        counter_next = ZERO;
                        tc_next      = 1'b1;
                    end else if (AUTO_RELOAD && (reload_reg != ZERO)) begin
                        counter_next = reload_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end
                HOLD: begin
                    if (start && !stop) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // busy is registered alongside state so it never glitches off the decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench: one-shot and periodic instances driven in parallel,
// compared every cycle against a behavioural model, then randomized traffic.
`timescale 1ns/1ps
module tb_down_counter_timer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic [3:0] counter0;
    logic [3:0] counter1;
    logic       busy0;
    logic       busy1;
    logic       tc0;
    logic       tc1;

    int checks;
    int passes;

    // Reference model: index 0 is one-shot, index 1 is periodic.
    int m_cnt  [2];
    int m_rel  [2];
    bit m_run  [2];
    bit m_hold [2];
    bit m_tc   [2];

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clock(clock), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .counter(counter0), .busy(busy0), .tc(tc0)
    );

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clock(clock), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .counter(counter1), .busy(busy1), .tc(tc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_rel[i]  = 0;
            m_run[i]  = 1'b0;
            m_hold[i] = 1'b0;
            m_tc[i]   = 1'b0;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 1'b0;
            if (load) begin
                m_cnt[i]  = int'(load_val);
                m_rel[i]  = int'(load_val);
                m_run[i]  = 1'b0;
                m_hold[i] = 1'b0;
            end else if (m_run[i]) begin
                if (stop) begin
                    m_run[i]  = 1'b0;
                    m_hold[i] = 1'b1;
                end else if (m_cnt[i] > 1) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else if (m_cnt[i] == 1) begin
                    m_cnt[i] = 0;
                    m_tc[i]  = 1'b1;
                end else if (i == 1 && m_rel[i] != 0) begin
                    m_cnt[i] = m_rel[i];
                end else begin
                    m_run[i] = 1'b0;
                end
            end else if (m_hold[i]) begin
                if (start && !stop) begin
                    m_hold[i] = 1'b0;
                    m_run[i]  = 1'b1;
                end
            end else if (start && !stop && m_cnt[i] != 0) begin
                m_run[i] = 1'b1;
            end
        end
    endtask

    task automatic checkValue(input string tag, input int actual, input int expected);
        checks++;
        assert (actual === expected) passes++;
        else $error("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " counter0"}, int'(counter0), m_cnt[0]);
        checkValue({tag, " busy0"},    int'(busy0),    int'(m_run[0] | m_hold[0]));
        checkValue({tag, " tc0"},      int'(tc0),      int'(m_tc[0]));
        checkValue({tag, " counter1"}, int'(counter1), m_cnt[1]);
        checkValue({tag, " busy1"},    int'(busy1),    int'(m_run[1] | m_hold[1]));
        checkValue({tag, " tc1"},      int'(tc1),      int'(m_tc[1]));
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare 1ns later.
    task automatic applyStimulus(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                                 input string tag);
        load     = ld;
        load_val = lv;
        start    = st;
        stop     = sp;
        @(posedge clock);
        if (!reset) modelReset();
        else modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        int seq3 [8];
        checks   = 0;
        passes   = 0;
        reset    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        start    = 1'b0;
        stop     = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset");
        #3 reset = 1'b1;

        // Zero load value must never start.
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, "zero load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "zero start");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, "zero idle");
            checkValue("zero busy", int'(busy0), 0);
            checkValue("zero tc", int'(tc0 | tc1), 0);
        end

        // One-shot countdown from 5.
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, "os load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "os start");
        checkValue("os first", int'(counter0), 5);
        for (int v = 4; v >= 0; v--) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, "os run");
            checkValue("os count", int'(counter0), v);
            checkValue("os tc", int'(tc0), (v == 0) ? 1 : 0);
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, "os done");
        checkValue("os busy end", int'(busy0), 0);
        checkValue("os count end", int'(counter0), 0);
        idle(3, "os idle");

        // Periodic reload from 3: period of 4 cycles.
        seq3 = '{2, 1, 0, 3, 2, 1, 0, 3};
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, "pr load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "pr start");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, "pr run");
            checkValue("pr count", int'(counter1), seq3[k]);
            checkValue("pr tc", int'(tc1), (seq3[k] == 0) ? 1 : 0);
            checkValue("pr busy", int'(busy1), 1);
        end

        // Pause at 6 and resume.
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, "hold load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "hold start");
        idle(3, "hold run");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, "hold stop");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, "hold wait");
            checkValue("hold count", int'(counter0), 6);
        end
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "hold resume");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, "hold dec");
        checkValue("hold dec count", int'(counter0), 5);

        // Load overrides start and stop.
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, "ovr load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "ovr start");
        idle(5, "ovr run");
        checkValue("ovr at4", int'(counter0), 4);
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, "ovr reload");
        checkValue("ovr count", int'(counter0), 2);
        checkValue("ovr busy", int'(busy0), 0);

        // Asynchronous reset mid-cycle while running at 6.
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, "ar load");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "ar start");
        idle(3, "ar run");
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("ar async");
        checkValue("ar count", int'(counter0), 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, "ar held");
        #2 reset = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(15) == 0), 4'($urandom_range(15)),
                          ($urandom_range(3) == 0), ($urandom_range(7) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
